ysyx_25040109_mc_seq: RTL and testbench
=======================================

# ysyx_25040109_mc_seq

Multi-cycle instruction sequencer that replaces the single-cycle PC/trap control of the RV32 core with a parametrised FSM driving valid/ready memory handshakes. It owns the PC, instruction latch, trap sequencing (mepc then mcause), and the write-enable strobes for the GPR and CSR files. Datapath units (IDU/EXU/LSU/RegisterFile) remain combinational around it and present decode results to it in the EXEC state.

## Interface
Parameters:
- XLEN, 32, data/address width
- RESET_PC, 32'h8000_0000, PC value after reset
- TIMEOUT, 255, max wait cycles for any handshake before an access fault (0 = disabled)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid / imem_req_ready  out / in  1  fetch request handshake
- imem_addr  out  XLEN  fetch address (= pc)
- imem_resp_valid, imem_resp_err  in  1  fetch response, bus error
- imem_rdata  in  32  fetched instruction
- dmem_req_valid / dmem_req_ready  out / in  1  data request handshake
- dmem_wr  out  1  1 = store request
- dmem_resp_valid, dmem_resp_err  in  1  load data / store ack, bus error
- dmem_rdata  in  XLEN  load data
- dec_is_load, dec_is_store, dec_is_ecall, dec_invalid, dec_gpr_we, dec_csr_we  in  1  decode flags from IDU/EXU
- dec_next_pc  in  XLEN  EXU next PC
- mtvec  in  XLEN  trap vector
- pc  out  XLEN  current PC
- inst  out  32  latched instruction
- load_data  out  XLEN  latched dmem_rdata
- gpr_we, csr_we  out  1  one-cycle write strobes
- trap_csr_we  out  1  trap CSR write strobe
- trap_csr_addr  out  12  0x341 or 0x342
- trap_csr_wdata  out  XLEN  pc or cause
- commit  out  1  one-cycle pulse per retired or trapped instruction
- mcycle, minstret  out  64  performance counters

## Operation
- States: FETCH, F_WAIT, EXEC, MEM, M_WAIT, WB, TRAP_EPC, TRAP_CAUSE.
- FETCH: imem_req_valid=1; on req_ready go F_WAIT.
- F_WAIT: on resp_valid latch inst. resp_err -> TRAP_EPC, cause 1. Otherwise -> EXEC.
- EXEC: dec_invalid -> TRAP_EPC, cause 2. dec_is_ecall -> TRAP_EPC, cause 11. load/store -> MEM. Else -> WB.
- MEM: dmem_req_valid=1, dmem_wr=dec_is_store; on req_ready go M_WAIT.
- M_WAIT: on resp_valid latch load_data. resp_err -> TRAP_EPC, cause 5 for load or 7 for store. Otherwise -> WB.
- WB: gpr_we=dec_gpr_we, csr_we=dec_csr_we, pc<=dec_next_pc, commit=1 -> FETCH.
- TRAP_EPC: trap_csr_we=1, addr 0x341, wdata=pc -> TRAP_CAUSE.
- TRAP_CAUSE: trap_csr_we=1, addr 0x342, wdata=cause, pc<=mtvec, commit=1 -> FETCH.
- Only one transition per cycle. Requests hold valid and address stable until ready.
- Timeout counter clears on every state entry and counts in FETCH, F_WAIT, MEM and M_WAIT.
  - Reaching TIMEOUT forces TRAP_EPC with the state's access-fault cause: 1 in FETCH/F_WAIT; 5 or 7 in MEM/M_WAIT.
  - resp_valid in the same cycle as the timeout wins.
- resp_valid outside F_WAIT/M_WAIT is ignored.
- gpr_we, csr_we and dmem_req are never asserted in a trapping path.

## Timing
- Reset state:
  - state=FETCH, pc=RESET_PC.
  - inst=0, load_data=0.
  - All strobes and valids 0; counters 0.
- The first imem_req_valid appears the cycle after rst_n deasserts.
- Zero-wait memory (ready immediately, resp next cycle):
  - ALU instruction: 4 cycles.
  - load/store: 6 cycles.
  - ecall/illegal: 5 cycles, with the next fetch at mtvec.
- Strobes are Moore outputs of the current state.
- Reset asserted mid-transaction clears immediately. Later responses are dropped because the FSM restarts in FETCH.

## Configuration
- YSYX_25040109_PERF_EN defined:
  - mcycle increments every cycle out of reset.
  - minstret increments on each WB commit (not on traps).
  - Both wrap at 2^64.
- Not defined: mcycle and minstret are tied to 0 and the counter flops are absent.

## Test plan
- Reset release, zero-wait imem returning addi, dec_next_pc=pc+4 -> pc 0x8000_0000 then 0x8000_0004; gpr_we single pulse at cycle 4.
- Load with dmem_req_ready delayed 3 cycles, rdata 0xDEADBEEF -> dmem_req_valid held and stable for 4 cycles; load_data=0xDEADBEEF; gpr_we once.
- ecall at pc 0x8000_0010, mtvec 0x8000_0100 -> trap writes 0x341←0x8000_0010 then 0x342←11; next imem_addr 0x8000_0100; no gpr_we.
- Store with dmem_resp_err -> trap cause 7, mepc=store pc, no gpr_we; minstret unchanged with PERF_EN.
- imem_resp_valid withheld, TIMEOUT=8 -> after 8 F_WAIT cycles trap cause 1. Separately, resp_valid on cycle 8 -> normal EXEC.
- rst_n pulsed low during M_WAIT -> outputs reset immediately; stale dmem_resp_valid after release ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ysyx_25040109_mc_seq.sv
// Multi-cycle RV32 sequencer: owns PC, instruction latch, trap sequencing and write strobes.
// Optional perf counters behind YSYX_25040109_PERF_EN; all outputs are Moore outputs of the current state.
module ysyx_25040109_mc_seq #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic            imem_resp_err,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_wr,
    input  logic            dmem_resp_valid,
    input  logic            dmem_resp_err,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dec_is_load,
    input  logic            dec_is_store,
    input  logic            dec_is_ecall,
    input  logic            dec_invalid,
    input  logic            dec_gpr_we,
    input  logic            dec_csr_we,
    input  logic [XLEN-1:0] dec_next_pc,
    input  logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] load_data,
    output logic            gpr_we,
    output logic            csr_we,
    output logic            trap_csr_we,
    output logic [11:0]     trap_csr_addr,
    output logic [XLEN-1:0] trap_csr_wdata,
    output logic            commit,
    output logic [63:0]     mcycle,
    output logic [63:0]     minstret
);

    typedef enum logic [2:0] {
        FETCH, F_WAIT, EXEC, MEM, M_WAIT, WB, TRAP_EPC, TRAP_CAUSE
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_t          state_q, state_d;
    logic [3:0]      cause_q, cause_d;
    logic [TW-1:0]   tcnt_q;
    logic            started_q;
    logic            tmo;
    logic            counting;
    logic [3:0]      mem_fault;

    // The last counted cycle of a wait is the deadline; a handshake on that cycle still wins.
    assign tmo       = (TIMEOUT != 0) && (tcnt_q == TMO_LAST);
    assign counting  = (state_q == FETCH) || (state_q == F_WAIT) ||
                       (state_q == MEM)   || (state_q == M_WAIT);
    assign mem_fault = dec_is_store ? 4'd7 : 4'd5;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            FETCH: begin
                if (started_q) begin
                    if (imem_req_ready) begin
                        state_d = F_WAIT;
                    end else if (tmo) begin
                        state_d = TRAP_EPC;
                        cause_d = 4'd1;
                    end
                end
            end
            F_WAIT: begin
                if (imem_resp_valid) begin
                    if (imem_resp_err) begin
                        state_d = TRAP_EPC;
                        cause_d = 4'd1;
                    end else begin
                        state_d = EXEC;
                    end
                end else if (tmo) begin
                    state_d = TRAP_EPC;
                    cause_d = 4'd1;
                end
            end
            EXEC: begin
                if (dec_invalid) begin
                    state_d = TRAP_EPC;
                    cause_d = 4'd2;
                end else if (dec_is_ecall) begin
                    state_d = TRAP_EPC;
                    cause_d = 4'd11;
                end else if (dec_is_load || dec_is_store) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (dmem_req_ready) begin
                    state_d = M_WAIT;
                end else if (tmo) begin
                    state_d = TRAP_EPC;
                    cause_d = mem_fault;
                end
            end
            M_WAIT: begin
                if (dmem_resp_valid) begin
                    if (dmem_resp_err) begin
                        state_d = TRAP_EPC;
                        cause_d = mem_fault;
                    end else begin
                        state_d = WB;
                    end
                end else if (tmo) begin
                    state_d = TRAP_EPC;
                    cause_d = mem_fault;
                end
            end
            WB:         state_d = FETCH;
            TRAP_EPC:   state_d = TRAP_CAUSE;
            TRAP_CAUSE: state_d = FETCH;
            default:    state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            cause_q   <= 4'd0;
            tcnt_q    <= '0;
            started_q <= 1'b0;
            pc        <= RESET_PC;
            inst      <= 32'd0;
            load_data <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            started_q <= 1'b1;
            if (state_d != state_q || !started_q) begin
                tcnt_q <= '0;
            end else if (counting) begin
                tcnt_q <= tcnt_q + 1'b1;
            end
            if (state_q == F_WAIT && imem_resp_valid) begin
                inst <= imem_rdata;
            end
            if (state_q == M_WAIT && dmem_resp_valid) begin
                load_data <= dmem_rdata;
            end
            if (state_q == WB) begin
                pc <= dec_next_pc;
            end else if (state_q == TRAP_CAUSE) begin
                pc <= mtvec;
            end
        end
    end

    assign imem_req_valid = (state_q == FETCH) && started_q;
    assign imem_addr      = pc;
    assign dmem_req_valid = (state_q == MEM);
    assign dmem_wr        = (state_q == MEM) && dec_is_store;
    assign gpr_we         = (state_q == WB) && dec_gpr_we;
    assign csr_we         = (state_q == WB) && dec_csr_we;
    assign trap_csr_we    = (state_q == TRAP_EPC) || (state_q == TRAP_CAUSE);
    assign trap_csr_addr  = (state_q == TRAP_CAUSE) ? 12'h342 :
                            (state_q == TRAP_EPC)   ? 12'h341 : 12'h000;
    assign trap_csr_wdata = (state_q == TRAP_CAUSE) ? {{(XLEN-4){1'b0}}, cause_q} :
                            (state_q == TRAP_EPC)   ? pc : '0;
    assign commit         = (state_q == WB) || (state_q == TRAP_CAUSE);

`ifdef YSYX_25040109_PERF_EN
    logic [63:0] mcycle_q, minstret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mcycle_q <= mcycle_q + 64'd1;
            if (state_q == WB) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

    assign mcycle   = mcycle_q;
    assign minstret = minstret_q;
`else
    assign mcycle   = 64'd0;
    assign minstret = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_25040109_mc_seq.sv
// Directed bench for ysyx_25040109_mc_seq: ALU, load, ecall, store fault, illegal, fetch timeout, mid-transaction reset.
module tb_ysyx_25040109_mc_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid, imem_resp_err;
    logic [31:0] imem_rdata;
    logic        dmem_req_valid, dmem_req_ready, dmem_wr;
    logic        dmem_resp_valid, dmem_resp_err;
    logic [31:0] dmem_rdata;
    logic        dec_is_load, dec_is_store, dec_is_ecall, dec_invalid, dec_gpr_we, dec_csr_we;
    logic [31:0] dec_next_pc, mtvec;
    logic [31:0] pc, inst, load_data;
    logic        gpr_we, csr_we, trap_csr_we, commit;
    logic [11:0] trap_csr_addr;
    logic [31:0] trap_csr_wdata;
    logic [63:0] mcycle, minstret;

    int checks = 0;
    int errors = 0;

    // Per-instruction observations recorded by run_instr.
    int          cyc, n_gpr, first_gpr, n_dreq, n_dwr, n_trap, n_commit;
    logic [11:0] tr_addr [2];
    logic [31:0] tr_dat  [2];
    logic        timed_out;

    always #5 clk = ~clk;

    ysyx_25040109_mc_seq #(.XLEN(32), .RESET_PC(32'h8000_0000), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_err(imem_resp_err), .imem_rdata(imem_rdata),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_wr(dmem_wr),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_err(dmem_resp_err), .dmem_rdata(dmem_rdata),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_is_ecall(dec_is_ecall),
        .dec_invalid(dec_invalid), .dec_gpr_we(dec_gpr_we), .dec_csr_we(dec_csr_we),
        .dec_next_pc(dec_next_pc), .mtvec(mtvec),
        .pc(pc), .inst(inst), .load_data(load_data),
        .gpr_we(gpr_we), .csr_we(csr_we),
        .trap_csr_we(trap_csr_we), .trap_csr_addr(trap_csr_addr), .trap_csr_wdata(trap_csr_wdata),
        .commit(commit), .mcycle(mcycle), .minstret(minstret)
    );

    task automatic idle_inputs();
        imem_req_ready  = 1'b0; imem_resp_valid = 1'b0; imem_resp_err = 1'b0; imem_rdata = 32'd0;
        dmem_req_ready  = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_err = 1'b0; dmem_rdata = 32'd0;
        dec_is_load = 1'b0; dec_is_store = 1'b0; dec_is_ecall = 1'b0; dec_invalid = 1'b0;
        dec_gpr_we  = 1'b0; dec_csr_we   = 1'b0; dec_next_pc  = 32'd0;
    endtask

    // Zero-wait-ready environment for one instruction, entered and left on a FETCH cycle.
    // ird: F_WAIT cycles before the fetch response (-1 = never); ddly: cycles before dmem ready.
    task automatic run_instr(input logic [31:0] instr, input int ird, input logic ierr,
                             input logic ld, input logic st, input logic ec, input logic inv,
                             input logic gwe, input int ddly, input logic derr, input logic [31:0] drd);
        bit   fwait = 0, mwait = 0, done = 0;
        int   wcnt = 0, dcnt = 0;
        logic ireq, dreq;
        cyc = 0; n_gpr = 0; first_gpr = 0; n_dreq = 0; n_dwr = 0; n_trap = 0; n_commit = 0;
        tr_addr[0] = '0; tr_addr[1] = '0; tr_dat[0] = '0; tr_dat[1] = '0;
        dec_is_load = ld; dec_is_store = st; dec_is_ecall = ec; dec_invalid = inv; dec_gpr_we = gwe;
        while (!done && cyc < 60) begin
            cyc++;
            if (gpr_we) begin n_gpr++; if (first_gpr == 0) first_gpr = cyc; end
            if (dmem_req_valid) begin n_dreq++; if (dmem_wr) n_dwr++; end
            if (trap_csr_we) begin
                if (n_trap < 2) begin tr_addr[n_trap] = trap_csr_addr; tr_dat[n_trap] = trap_csr_wdata; end
                n_trap++;
            end
            if (commit) begin n_commit++; done = 1; end
            dec_next_pc     = pc + 32'd4;
            imem_req_ready  = 1'b1;
            imem_resp_valid = fwait && (wcnt == ird);
            imem_resp_err   = ierr;
            imem_rdata      = instr;
            dmem_req_ready  = dmem_req_valid && (dcnt == ddly);
            dmem_resp_valid = mwait;
            dmem_resp_err   = derr;
            dmem_rdata      = drd;
            ireq = imem_req_valid;
            dreq = dmem_req_valid;
            @(posedge clk); #1;
            if (fwait) begin
                if (imem_resp_valid) fwait = 0; else wcnt++;
            end else if (ireq && imem_req_ready) begin
                fwait = 1; wcnt = 0;
            end
            if (mwait) begin
                mwait = 0;
            end else if (dreq) begin
                if (dmem_req_ready) begin mwait = 1; dcnt = 0; end else dcnt++;
            end
        end
        timed_out = !done;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        mtvec = 32'h8000_0100;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h8000_0000); end checks++;
        if (inst !== 32'd0) begin errors++; $display("FAIL reset_inst got %h exp 0", inst); end checks++;
        if (load_data !== 32'd0) begin errors++; $display("FAIL reset_load_data got %h exp 0", load_data); end checks++;
        if ({imem_req_valid, dmem_req_valid, gpr_we, csr_we, trap_csr_we, commit} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes got %b exp 000000", {imem_req_valid, dmem_req_valid, gpr_we, csr_we, trap_csr_we, commit});
        end checks++;
        if (mcycle !== 64'd0 || minstret !== 64'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", mcycle, minstret); end checks++;
        rst_n = 1'b1;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL release_no_req got %b exp 0", imem_req_valid); end checks++;
        @(posedge clk); #1;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0000) begin
            errors++; $display("FAIL first_fetch got v=%b a=%h exp v=1 a=80000000", imem_req_valid, imem_addr);
        end checks++;
    endtask

    task automatic test_alu();
        run_instr(32'h0010_0093, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'd0);
        if (timed_out || cyc !== 4) begin errors++; $display("FAIL alu_cycles got %0d to=%b exp 4", cyc, timed_out); end checks++;
        if (n_gpr !== 1 || first_gpr !== 4) begin errors++; $display("FAIL alu_gpr_we got n=%0d at %0d exp n=1 at 4", n_gpr, first_gpr); end checks++;
        if (n_trap !== 0) begin errors++; $display("FAIL alu_no_trap got %0d exp 0", n_trap); end checks++;
        if (inst !== 32'h0010_0093) begin errors++; $display("FAIL alu_inst got %h exp 00100093", inst); end checks++;
        if (pc !== 32'h8000_0004 || imem_addr !== 32'h8000_0004) begin
            errors++; $display("FAIL alu_next_pc got pc=%h addr=%h exp 80000004", pc, imem_addr);
        end checks++;
    endtask

    task automatic test_load();
        run_instr(32'h0000_a103, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 32'hDEAD_BEEF);
        if (timed_out || cyc !== 9) begin errors++; $display("FAIL load_cycles got %0d to=%b exp 9", cyc, timed_out); end checks++;
        if (n_dreq !== 4 || n_dwr !== 0) begin errors++; $display("FAIL load_req_hold got %0d wr=%0d exp 4 wr=0", n_dreq, n_dwr); end checks++;
        if (load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data got %h exp deadbeef", load_data); end checks++;
        if (n_gpr !== 1 || first_gpr !== 9) begin errors++; $display("FAIL load_gpr_we got n=%0d at %0d exp n=1 at 9", n_gpr, first_gpr); end checks++;
        if (pc !== 32'h8000_0008) begin errors++; $display("FAIL load_next_pc got %h exp 80000008", pc); end checks++;
    endtask

    task automatic test_back_to_back();
        run_instr(32'h0020_8113, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'd0);
        if (pc !== 32'h8000_000C || cyc !== 4) begin errors++; $display("FAIL b2b_first got pc=%h cyc=%0d exp 8000000c/4", pc, cyc); end checks++;
        run_instr(32'h0031_0193, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'd0);
        if (pc !== 32'h8000_0010 || cyc !== 4) begin errors++; $display("FAIL b2b_second got pc=%h cyc=%0d exp 80000010/4", pc, cyc); end checks++;
    endtask

    task automatic test_ecall();
        run_instr(32'h0000_0073, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'd0);
        if (timed_out || cyc !== 5) begin errors++; $display("FAIL ecall_cycles got %0d to=%b exp 5", cyc, timed_out); end checks++;
        if (n_trap !== 2 || tr_addr[0] !== 12'h341 || tr_dat[0] !== 32'h8000_0010) begin
            errors++; $display("FAIL ecall_mepc got n=%0d %h<-%h exp 2 341<-80000010", n_trap, tr_addr[0], tr_dat[0]);
        end checks++;
        if (tr_addr[1] !== 12'h342 || tr_dat[1] !== 32'd11) begin
            errors++; $display("FAIL ecall_mcause got %h<-%0d exp 342<-11", tr_addr[1], tr_dat[1]);
        end checks++;
        if (n_gpr !== 0 || n_dreq !== 0) begin errors++; $display("FAIL ecall_no_side_effects got gpr=%0d dreq=%0d exp 0/0", n_gpr, n_dreq); end checks++;
        if (imem_addr !== 32'h8000_0100 || imem_req_valid !== 1'b1) begin
            errors++; $display("FAIL ecall_vector got %h v=%b exp 80000100 v=1", imem_addr, imem_req_valid);
        end checks++;
    endtask

    task automatic test_store_err();
        logic [63:0] ret_before;
        ret_before = minstret;
        run_instr(32'h0020_a023, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'd0);
        if (timed_out || cyc !== 7) begin errors++; $display("FAIL store_err_cycles got %0d to=%b exp 7", cyc, timed_out); end checks++;
        if (n_dwr !== 1) begin errors++; $display("FAIL store_wr got %0d exp 1", n_dwr); end checks++;
        if (n_trap !== 2 || tr_dat[0] !== 32'h8000_0100 || tr_dat[1] !== 32'd7) begin
            errors++; $display("FAIL store_err_trap got n=%0d epc=%h cause=%0d exp 2 80000100 7", n_trap, tr_dat[0], tr_dat[1]);
        end checks++;
        if (n_gpr !== 0) begin errors++; $display("FAIL store_err_gpr got %0d exp 0", n_gpr); end checks++;
        if (minstret !== ret_before) begin errors++; $display("FAIL store_err_minstret got %0d exp %0d", minstret, ret_before); end checks++;
    endtask

    task automatic test_illegal();
        run_instr(32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 32'd0);
        if (cyc !== 5 || n_trap !== 2 || tr_dat[1] !== 32'd2 || n_gpr !== 0) begin
            errors++; $display("FAIL illegal_trap got cyc=%0d n=%0d cause=%0d gpr=%0d exp 5 2 2 0", cyc, n_trap, tr_dat[1], n_gpr);
        end checks++;
    endtask

    task automatic test_fetch_timeout();
        run_instr(32'h0010_0093, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'd0);
        if (timed_out || cyc !== 11) begin errors++; $display("FAIL fetch_timeout_cycles got %0d to=%b exp 11", cyc, timed_out); end checks++;
        if (n_trap !== 2 || tr_dat[0] !== 32'h8000_0100 || tr_dat[1] !== 32'd1 || n_gpr !== 0) begin
            errors++; $display("FAIL fetch_timeout_trap got n=%0d epc=%h cause=%0d gpr=%0d exp 2 80000100 1 0", n_trap, tr_dat[0], tr_dat[1], n_gpr);
        end checks++;
        run_instr(32'h0010_0093, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'd0);
        if (timed_out || cyc !== 11 || n_trap !== 0 || n_gpr !== 1) begin
            errors++; $display("FAIL fetch_last_cycle_resp got cyc=%0d trap=%0d gpr=%0d exp 11 0 1", cyc, n_trap, n_gpr);
        end checks++;
        if (pc !== 32'h8000_0104) begin errors++; $display("FAIL fetch_last_cycle_pc got %h exp 80000104", pc); end checks++;
    endtask

    task automatic test_reset_mid();
        dec_is_load = 1'b1; dec_gpr_we = 1'b1;
        imem_req_ready = 1'b1;
        @(posedge clk); #1;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_rdata = 32'h0000_a103;
        @(posedge clk); #1;
        imem_resp_valid = 1'b0;
        @(posedge clk); #1;
        if (dmem_req_valid !== 1'b1) begin errors++; $display("FAIL mid_mem_req got %b exp 1", dmem_req_valid); end checks++;
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        if (pc !== 32'h8000_0000 || inst !== 32'd0 || load_data !== 32'd0) begin
            errors++; $display("FAIL mid_reset_regs got pc=%h inst=%h ld=%h exp 80000000 0 0", pc, inst, load_data);
        end checks++;
        if ({imem_req_valid, dmem_req_valid, gpr_we, commit} !== 4'b0) begin
            errors++; $display("FAIL mid_reset_strobes got %b exp 0000", {imem_req_valid, dmem_req_valid, gpr_we, commit});
        end checks++;
        dmem_resp_valid = 1'b1; dmem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0000) begin
            errors++; $display("FAIL mid_restart got v=%b a=%h exp v=1 a=80000000", imem_req_valid, imem_addr);
        end checks++;
        repeat (2) @(posedge clk);
        #1;
        if (load_data !== 32'd0 || gpr_we !== 1'b0 || dmem_req_valid !== 1'b0) begin
            errors++; $display("FAIL mid_stale_resp got ld=%h gpr=%b dreq=%b exp 0 0 0", load_data, gpr_we, dmem_req_valid);
        end checks++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_back_to_back();
        test_ecall();
        test_store_err();
        test_illegal();
        test_fetch_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
